// File: rtl/traffic_timer.sv
// traffic_timer: interval timer returning short/long expiry flags to the traffic-light controller
//   clk    in        system clock, rising edge
//   reset  in        asynchronous active-low reset
//   st     in        start/restart request, sampled on rising clk
//   ts     out       short interval elapsed, sticky until next st or reset
//   tl     out       long interval elapsed, sticky until next st or reset
//   busy   out       timer running (RUN_SHORT or RUN_LONG)
//   count  out CNT_W current tick count, saturates at LONG_CYCLES
module traffic_timer #(
    parameter int SHORT_CYCLES = 5,
    parameter int LONG_CYCLES  = 20,
    parameter int PRESCALE     = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st,
    output logic             ts,
    output logic             tl,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    typedef enum logic [1:0] {IDLE, RUN_SHORT, RUN_LONG, EXPIRED} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic [PW-1:0]    r_pre;
    logic             w_busy, w_tick;
    assign w_busy    = r_state == RUN_SHORT || r_state == RUN_LONG;
    assign w_tick    = w_busy && r_pre == PW'(PRESCALE - 1);
    assign w_cnt_inc = r_cnt + 1'b1;
    // count only moves on ticks, which only happen while busy, so it holds in IDLE/EXPIRED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= st ? '0 : w_tick ? w_cnt_inc : r_cnt;
            r_pre   <= (st || w_tick || !w_busy) ? '0 : r_pre + 1'b1;
        end
    end
    always_comb begin
        w_state_nxt = st ? RUN_SHORT :
                      (r_state == RUN_SHORT && w_tick && w_cnt_inc == CNT_W'(SHORT_CYCLES)) ? RUN_LONG :
                      (r_state == RUN_LONG && w_tick && w_cnt_inc == CNT_W'(LONG_CYCLES)) ? EXPIRED :
                      r_state;
    end
    // flags decode straight from the state register, so st never reaches an output combinationally
    always_comb begin
        busy  = w_busy;
        ts    = r_state == RUN_LONG || r_state == EXPIRED;
        tl    = r_state == EXPIRED;
        count = r_cnt;
    end
endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: checks two timers (PRESCALE 1 and 4) against an elapsed-clock reference model
module tb_traffic_timer;
    localparam int SHORT = 5;
    localparam int LONG  = 20;
    localparam int PB    = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       st_a = 1'b0, st_b = 1'b0;
    logic       ts_a, tl_a, busy_a, ts_b, tl_b, busy_b;
    logic [7:0] cnt_a, cnt_b;
    int         ea = -1, eb = -1;
    int         n_cmp = 0, n_fail = 0;
    always #5 clk = ~clk;
    traffic_timer u_a (
        .clk(clk), .reset(reset), .st(st_a),
        .ts(ts_a), .tl(tl_a), .busy(busy_a), .count(cnt_a)
    );
    traffic_timer #(.PRESCALE(PB)) u_b (
        .clk(clk), .reset(reset), .st(st_b),
        .ts(ts_b), .tl(tl_b), .busy(busy_b), .count(cnt_b)
    );
    // e = clocks elapsed since the last sampled st (-1 = never started / reset)
    function automatic int ecnt(int e, int p);
        if (e < 0) return 0;
        return (e / p > LONG) ? LONG : e / p;
    endfunction
    task automatic chk1(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk(string tag);
        int ca = ecnt(ea, 1);
        int cb = ecnt(eb, PB);
        chk1({tag, " a.count"}, int'(cnt_a), ca);
        chk1({tag, " a.ts"}, int'(ts_a), int'(ca >= SHORT));
        chk1({tag, " a.tl"}, int'(tl_a), int'(ca >= LONG));
        chk1({tag, " a.busy"}, int'(busy_a), int'(ea >= 0 && ca < LONG));
        chk1({tag, " b.count"}, int'(cnt_b), cb);
        chk1({tag, " b.ts"}, int'(ts_b), int'(cb >= SHORT));
        chk1({tag, " b.tl"}, int'(tl_b), int'(cb >= LONG));
        chk1({tag, " b.busy"}, int'(busy_b), int'(eb >= 0 && cb < LONG));
    endtask
    task automatic step(logic sa, logic sb, string tag);
        st_a = sa;
        st_b = sb;
        @(posedge clk);
        if (reset) begin
            ea = sa ? 0 : (ea >= 0 ? ea + 1 : -1);
            eb = sb ? 0 : (eb >= 0 ? eb + 1 : -1);
        end
        @(negedge clk);
        chk(tag);
    endtask
    task automatic run(int n, logic sa, logic sb, string tag);
        for (int i = 0; i < n; i++) step(sa, sb, tag);
    endtask
    initial begin
        st_a = 1'b1;
        st_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("in_reset");
        end
        reset = 1'b1;
        st_a  = 1'b0;
        st_b  = 1'b0;
        #1 chk("post_reset");
        run(5, 0, 0, "idle");
        step(1, 1, "start");
        run(30, 0, 0, "run_expire_hold");
        step(1, 0, "restart1");
        run(3, 0, 0, "to3");
        step(1, 0, "pulse_at3");
        run(12, 0, 0, "to12");
        step(1, 0, "pulse_at12");
        run(25, 0, 0, "after_pulses");
        step(1, 0, "start4");
        run(4, 0, 0, "to4");
        step(1, 0, "st_on_short");
        run(6, 0, 0, "after_short_clash");
        run(19, 1, 0, "st_held");
        step(1, 0, "st_on_long");
        run(5, 0, 0, "after_long_clash");
        step(0, 1, "presc_start");
        run(90, 0, 0, "presc_run");
        step(1, 1, "pre_async");
        run(9, 0, 0, "to9");
        #2 reset = 1'b0;
        #1 begin
            ea = -1;
            eb = -1;
        end
        chk("async_reset");
        @(negedge clk);
        chk("reset_hold");
        reset = 1'b1;
        run(30, 0, 0, "no_expiry");
        for (int i = 0; i < 300; i++)
            step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 29) == 0), "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Interval timer that closes the loop with the traffic-light Mealy controller.
- Consumes the controller's start-timer request `st`.
- Returns the short-interval expiry `ts` and long-interval expiry `tl` the controller branches on.
- Sits beside the controller in the intersection top level, clocked from the same `clk`.

Parameters:
- SHORT_CYCLES, 5, ticks until `ts` asserts (yellow interval); must be ≥1 and < LONG_CYCLES.
- LONG_CYCLES, 20, ticks until `tl` asserts (minimum green interval); must be < 2**CNT_W.
- PRESCALE, 1, clk cycles per timer tick; must be ≥1.
- CNT_W, 8, width of tick counter and `count` output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- st  in  1  start/restart timer request from the controller, sampled on rising clk.
- ts  out  1  short interval elapsed; level, sticky until the next `st` or reset.
- tl  out  1  long interval elapsed; level, sticky until the next `st` or reset.
- busy  out  1  timer running (RUN_SHORT or RUN_LONG).
- count  out  CNT_W  current tick count, for debug and the bench.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, prescaler=0, ts=0, tl=0, busy=0. Outputs hold these values for as long as reset is low.
- States: IDLE, RUN_SHORT, RUN_LONG, EXPIRED. All outputs are registered; no combinational path from `st` to any output.
- `st`=1 at any edge, in any state, overrides everything else:
  - next state=RUN_SHORT; count=0; prescaler=0; ts=0; tl=0; busy=1.
- Tick generation: the prescaler counts 0..PRESCALE-1 while busy. A tick occurs on the edge where the prescaler equals PRESCALE-1, and the prescaler wraps to 0. With PRESCALE=1 every clk is a tick.
- On each tick while busy, count increments by 1.
- RUN_SHORT → RUN_LONG on the tick that makes count=SHORT_CYCLES. ts is set to 1 on that same edge.
- RUN_LONG → EXPIRED on the tick that makes count=LONG_CYCLES. tl is set to 1 on that same edge; busy clears to 0.
- EXPIRED:
  - count holds at LONG_CYCLES (saturates, no wrap).
  - ts=1 and tl=1 hold.
  - Stays here until `st` or reset.
- IDLE: count=0 and all flags 0; only `st` leaves IDLE.
- Latency, PRESCALE=1, `st` sampled at edge k:
  - count=n after edge k+n.
  - ts rises after edge k+SHORT_CYCLES.
  - tl rises after edge k+LONG_CYCLES.
  - In general, multiply the tick counts by PRESCALE.
- Boundary conditions:
  - `st` on the same edge as a short or long expiry: `st` wins. Flags stay/return to 0 and count=0.
  - `st` held high continuously: timer stays at count=0, busy=1, ts=tl=0 (restart every cycle).
  - `st` pulse mid-run: restart from 0. Previously set ts clears on that edge.
  - Reset mid-run: immediate clear to the reset values; no expiry is reported afterwards.
  - count never exceeds LONG_CYCLES; there is no wrap-around in any state.
- Protocol with controller: the controller pulses `st` on entering a timed state. It then waits for ts or tl; flags remain valid until the controller's next `st`.

Test Plan:
1. Reset low 3 cycles with `st`=1, then release → ts=0, tl=0, busy=0, count=0; IDLE holds with `st`=0.
2. Defaults (PRESCALE=1), 1-cycle `st` at edge k → count=5 and ts=1 after edge k+5. tl=1, busy=0, count=20 after edge k+20. All values hold for 10 more cycles.
3. `st` pulse at count=3, then again at count=12 → each pulse zeroes count and ts. ts re-asserts exactly 5 cycles after the last pulse; tl 20 cycles after.
4. `st` asserted on the edge where count would reach 5 → ts stays 0, count=0. Then ts=1 five cycles later.
5. PRESCALE=4, single `st` → count increments every 4 clks. ts after 20 clks, tl after 80 clks.
6. reset driven low asynchronously mid-RUN_LONG (count=9, between edges) → ts, tl, busy, count go to 0 immediately. After release with no `st`, no expiry occurs over 30 cycles.
